// File: rtl/refclk_io_buffer_model_if.sv
// ---------------------------------------------------------------------------
// refclk_io_buffer_model_if
//   Board-level I/O bundle for the PCIe endpoint top-level buffer model.
//   Carries everything except the reference clock (sys_clk) and the
//   block reset (sys_rst), which stay plain ports on the model.
//
//   Signals
//     ceb          clock-enable-bar, 1 gates off refclk_o / refclk_odiv2
//     refclk_o     gated reference clock
//     refclk_odiv2 ODIV2 output (copy, /2 or static 0)
//     rst_n_pad    raw active-low board reset pad
//     rst_n_o      buffered copy of rst_n_pad
//     rst_n_sync   rst_n_pad synchronized to sys_clk
//     led_i        LED drive from the application
//     led_pad      LED pad outputs
//
//   Modports
//     master  : application / board side (drives ceb, rst_n_pad, led_i)
//     slave   : buffer model side
// ---------------------------------------------------------------------------
interface refclk_io_buffer_model_if #(
    parameter int NUM_LEDS = 4
);
    logic                ceb;
    logic                refclk_o;
    logic                refclk_odiv2;
    logic                rst_n_pad;
    logic                rst_n_o;
    logic                rst_n_sync;
    logic [NUM_LEDS-1:0] led_i;
    logic [NUM_LEDS-1:0] led_pad;

    modport master (
        output ceb,
        output rst_n_pad,
        output led_i,
        input  refclk_o,
        input  refclk_odiv2,
        input  rst_n_o,
        input  rst_n_sync,
        input  led_pad
    );

    modport slave (
        input  ceb,
        input  rst_n_pad,
        input  led_i,
        output refclk_o,
        output refclk_odiv2,
        output rst_n_o,
        output rst_n_sync,
        output led_pad
    );
endinterface

// File: rtl/refclk_io_buffer_model.sv
// ---------------------------------------------------------------------------
// refclk_io_buffer_model
//   Synthesizable behavioural stand-in for the vendor I/O buffer primitives
//   at the PCIe endpoint top level: reference-clock receiver (O / ODIV2),
//   reset input buffer with a synchronized copy, and LED output buffers.
//
//   Parameters
//     REFCLK_HROW_CK_SEL  ODIV2 mode: 00 copy of O, 01 O/2, 10/11 static 0
//     NUM_LEDS            number of LED output buffers (1..32)
//     RST_SYNC_STAGES     depth of the rst_n_sync chain (2..4)
//
//   Ports
//     sys_clk   reference clock after the differential receiver
//     sys_rst   asynchronous active-high reset
//     io        refclk_io_buffer_model_if.slave bundle (ceb, refclk_o,
//               refclk_odiv2, rst_n_pad, rst_n_o, rst_n_sync, led_i,
//               led_pad)
//
//   Optional feature (macro REFCLK_CEB_SYNC_EN)
//     Defined  : ceb is passed through two falling-edge flops before it
//                gates the clock, so the gate only moves while sys_clk is
//                low and refclk_o never carries a runt pulse.
//     Undefined: ceb gates combinationally with zero latency.
// ---------------------------------------------------------------------------

// One LED output buffer lane: pad follows the application drive.
module refclk_led_obuf (
    input  logic i,
    output logic o
);
    assign o = i;
endmodule

// Reset synchronizer: asserts asynchronously through clr, releases after
// STAGES rising edges of clk with d high.
module refclk_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];
endmodule

`ifdef REFCLK_CEB_SYNC_EN
// Falling-edge ceb synchronizer. Resets to "gated" so the clock stays off
// until two falling edges have seen ceb low after sys_rst releases.
module refclk_ceb_sync (
    input  logic clk,
    input  logic rst,
    input  logic ceb,
    output logic ceb_q
);
    logic [1:0] ceb_pipe;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) ceb_pipe <= 2'b11;
        else     ceb_pipe <= {ceb_pipe[0], ceb};
    end

    assign ceb_q = ceb_pipe[1];
endmodule
`endif

module refclk_io_buffer_model #(
    parameter logic [1:0] REFCLK_HROW_CK_SEL = 2'b00,
    parameter int         NUM_LEDS           = 4,
    parameter int         RST_SYNC_STAGES    = 2
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    refclk_io_buffer_model_if.slave         io
);
    // Keep the synchronizer depth inside its legal range even if a caller
    // passes something odd; a 1-flop chain would not synchronize at all.
    localparam int SYNC_N = (RST_SYNC_STAGES < 2) ? 2 :
                            (RST_SYNC_STAGES > 4) ? 4 : RST_SYNC_STAGES;

    // -----------------------------------------------------------------
    // Effective clock-enable-bar
    // -----------------------------------------------------------------
    logic ceb_eff;

`ifdef REFCLK_CEB_SYNC_EN
    refclk_ceb_sync u_ceb_sync (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .ceb   (io.ceb),
        .ceb_q (ceb_eff)
    );
`else
    assign ceb_eff = io.ceb;
`endif

    // Single gating term shared by O and ODIV2; no priority between reset
    // and ceb beyond the AND.
    logic en;
    assign en = ~sys_rst & ~ceb_eff;

    // -----------------------------------------------------------------
    // Reference clock receiver
    // -----------------------------------------------------------------
    logic refclk_o;
    assign refclk_o = sys_clk & en;

    // Divide-by-2 state. Cleared asynchronously whenever the clock is
    // gated so the first enabled rising edge always takes it to 1 and the
    // /2 output rises in phase with that edge.
    logic div_clr;
    logic div_q;

    assign div_clr = sys_rst | ceb_eff;

    always_ff @(posedge sys_clk or posedge div_clr) begin
        if (div_clr) div_q <= 1'b0;
        else         div_q <= ~div_q;
    end

    logic refclk_odiv2;

    always_comb begin
        refclk_odiv2 = 1'b0;
        case (REFCLK_HROW_CK_SEL)
            2'b00:   refclk_odiv2 = refclk_o;
            2'b01:   refclk_odiv2 = div_q & en;
            default: refclk_odiv2 = 1'b0;
        endcase
    end

    assign io.refclk_o     = refclk_o;
    assign io.refclk_odiv2 = refclk_odiv2;

    // -----------------------------------------------------------------
    // Reset input buffer and synchronized copy
    // -----------------------------------------------------------------
    logic rst_clr;
    logic rst_n_sync;

    assign rst_clr   = ~io.rst_n_pad | sys_rst;
    assign io.rst_n_o = io.rst_n_pad;

    refclk_rst_sync #(
        .STAGES (SYNC_N)
    ) u_rst_sync (
        .clk (sys_clk),
        .clr (rst_clr),
        .d   (io.rst_n_pad),
        .q   (rst_n_sync)
    );

    assign io.rst_n_sync = rst_n_sync;

    // -----------------------------------------------------------------
    // LED output buffers, one lane per pad
    // -----------------------------------------------------------------
    logic [NUM_LEDS-1:0] led_pad;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
        refclk_led_obuf u_led_obuf (
            .i (io.led_i[g]),
            .o (led_pad[g])
        );
    end

    assign io.led_pad = led_pad;

endmodule

// File: tb/tb_refclk_io_buffer_model.sv
module tb_refclk_io_buffer_model;
    localparam int NL = 4;
`ifdef REFCLK_CEB_SYNC_EN
    localparam int EN_LAT = 1;  // enabled edges lag ceb/reset changes by one
`else
    localparam int EN_LAT = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          ceb;
    logic          rst_n_pad;
    logic [NL-1:0] led_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    refclk_io_buffer_model_if #(.NUM_LEDS(NL)) ifc00 ();
    refclk_io_buffer_model_if #(.NUM_LEDS(NL)) ifc01 ();
    refclk_io_buffer_model_if #(.NUM_LEDS(NL)) ifc10 ();

    assign ifc00.ceb = ceb;  assign ifc00.rst_n_pad = rst_n_pad;  assign ifc00.led_i = led_i;
    assign ifc01.ceb = ceb;  assign ifc01.rst_n_pad = rst_n_pad;  assign ifc01.led_i = led_i;
    assign ifc10.ceb = ceb;  assign ifc10.rst_n_pad = rst_n_pad;  assign ifc10.led_i = led_i;

    refclk_io_buffer_model #(.REFCLK_HROW_CK_SEL(2'b00), .NUM_LEDS(NL), .RST_SYNC_STAGES(2))
        u_dut00 (.sys_clk(sys_clk), .sys_rst(sys_rst), .io(ifc00.slave));
    refclk_io_buffer_model #(.REFCLK_HROW_CK_SEL(2'b01), .NUM_LEDS(NL), .RST_SYNC_STAGES(2))
        u_dut01 (.sys_clk(sys_clk), .sys_rst(sys_rst), .io(ifc01.slave));
    refclk_io_buffer_model #(.REFCLK_HROW_CK_SEL(2'b10), .NUM_LEDS(NL), .RST_SYNC_STAGES(2))
        u_dut10 (.sys_clk(sys_clk), .sys_rst(sys_rst), .io(ifc10.slave));

    // rising-edge counters on the output clocks
    int c00_o = 0, c00_d = 0, c01_d = 0, c10_o = 0, c10_d = 0;
    always @(posedge ifc00.refclk_o)     c00_o++;
    always @(posedge ifc00.refclk_odiv2) c00_d++;
    always @(posedge ifc01.refclk_odiv2) c01_d++;
    always @(posedge ifc10.refclk_o)     c10_o++;
    always @(posedge ifc10.refclk_odiv2) c10_d++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic push(input string tag, input logic [31:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        sb_t s;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            s = sb_q.pop_front();
            chk(s.tag, got, s.exp);
        end
    endtask

    task automatic push_lvl(input string tag, input logic e_o, input logic e00,
                            input logic e01, input logic e10);
        push({tag, "_o00"}, 32'(e_o));
        push({tag, "_o01"}, 32'(e_o));
        push({tag, "_o10"}, 32'(e_o));
        push({tag, "_d00"}, 32'(e00));
        push({tag, "_d01"}, 32'(e01));
        push({tag, "_d10"}, 32'(e10));
    endtask

    task automatic pop_lvl();
        pop_chk(32'(ifc00.refclk_o));
        pop_chk(32'(ifc01.refclk_o));
        pop_chk(32'(ifc10.refclk_o));
        pop_chk(32'(ifc00.refclk_odiv2));
        pop_chk(32'(ifc01.refclk_odiv2));
        pop_chk(32'(ifc10.refclk_odiv2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    int b00_o, b00_d, b01_d, b10_o, b10_d;

    initial begin
        sys_rst   = 1'b1;
        ceb       = 1'b0;
        rst_n_pad = 1'b0;
        led_i     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge sys_clk);
        #1;
        push_lvl("rst_hi", 0, 0, 0, 0); pop_lvl();
        push("rst_sync", 0); pop_chk(32'(ifc00.rst_n_sync));
        #5;
        push_lvl("rst_lo", 0, 0, 0, 0); pop_lvl();

        led_i = 4'b1010; push("led_rst", 32'hA); #1 pop_chk(32'(ifc00.led_pad));
        rst_n_pad = 1'b1; push("rst_o_hi", 1); #1 pop_chk(32'(ifc00.rst_n_o));
        rst_n_pad = 1'b0; push("rst_o_lo", 0); #1 pop_chk(32'(ifc00.rst_n_o));
        rst_n_pad = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        push("sync_held_sysrst", 0); pop_chk(32'(ifc00.rst_n_sync));

        // ---------------- release, modes 00/01/10 ----------------
        sys_rst = 1'b0;
        #1;
        b00_o = c00_o; b00_d = c00_d; b01_d = c01_d; b10_o = c10_o; b10_d = c10_d;
        for (int j = 1; j <= 50 + EN_LAT; j++) begin
            int k;
            k = j - EN_LAT;
            @(posedge sys_clk);
            #1;
            if (j <= 2) begin
                push("sync_rel", 32'(j == 2)); pop_chk(32'(ifc00.rst_n_sync));
            end
            if (k < 1) push_lvl("pre_en_hi", 0, 0, 0, 0);
            else       push_lvl("run_hi", 1, 1, (k % 2) == 1, 0);
            pop_lvl();
            #5;
            if (k < 1) push_lvl("pre_en_lo", 0, 0, 0, 0);
            else       push_lvl("run_lo", 0, 0, (k % 2) == 1, 0);
            pop_lvl();
            if (k == 10) begin
                push("cnt00_o", 10); pop_chk(32'(c00_o - b00_o));
                push("cnt00_d", 10); pop_chk(32'(c00_d - b00_d));
            end
            if (k == 20) begin
                push("cnt01_d", 10); pop_chk(32'(c01_d - b01_d));
            end
            if (k == 50) begin
                push("cnt10_o", 50); pop_chk(32'(c10_o - b10_o));
                push("cnt10_d", 0);  pop_chk(32'(c10_d - b10_d));
            end
        end

        // ---------------- ceb gating ----------------
        @(posedge sys_clk);
        #1;
        ceb = 1'b1;
        for (int j = 1; j <= 5 + EN_LAT; j++) begin
            @(posedge sys_clk);
            #1;
            if (j > EN_LAT) begin
                push_lvl("gated_hi", 0, 0, 0, 0); pop_lvl();
                push("gated_led", 32'hA); pop_chk(32'(ifc01.led_pad));
            end
            #5;
            if (j > EN_LAT) begin
                push_lvl("gated_lo", 0, 0, 0, 0); pop_lvl();
            end
        end
        @(posedge sys_clk);
        #1;
        ceb = 1'b0;
        for (int j = 1; j <= 4 + EN_LAT; j++) begin
            int k;
            k = j - EN_LAT;
            @(posedge sys_clk);
            #1;
            if (k >= 1) begin
                push_lvl("restart_hi", 1, 1, (k % 2) == 1, 0); pop_lvl();
            end
            #5;
            if (k >= 1) begin
                push_lvl("restart_lo", 0, 0, (k % 2) == 1, 0); pop_lvl();
            end
        end

        // ---------------- reset synchronizer ----------------
        @(posedge sys_clk);
        #1;
        rst_n_pad = 1'b0;
        push("sync_async_clr", 0); push("rst_o_pad0", 0); push("clk_unaffected", 1);
        #1;
        pop_chk(32'(ifc00.rst_n_sync));
        pop_chk(32'(ifc00.rst_n_o));
        pop_chk(32'(ifc00.refclk_o));
        #5;
        rst_n_pad = 1'b1;
        for (int j = 1; j <= 2; j++) begin
            @(posedge sys_clk);
            #1;
            push("sync_rise", 32'(j == 2)); pop_chk(32'(ifc00.rst_n_sync));
        end

        // ---------------- sys_rst mid-operation ----------------
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        led_i   = 4'b0101;
        push_lvl("sysrst_mid", 0, 0, 0, 0);
        push("sysrst_sync", 0); push("sysrst_rst_o", 1); push("sysrst_led", 32'h5);
        #1;
        pop_lvl();
        pop_chk(32'(ifc00.rst_n_sync));
        pop_chk(32'(ifc00.rst_n_o));
        pop_chk(32'(ifc10.led_pad));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/refclk_io_buffer_model.md
Name: refclk_io_buffer_model

Overview:
- Synthesizable behavioural model of the board-level I/O buffers at the PCIe endpoint top level.
- Reference-clock receiver: O output plus ODIV2 output with selectable mode.
- Reset input buffer with an additional synchronized copy.
- LED output buffers.
- Used in simulation and lint builds in place of vendor primitives. All refclk-derived outputs are gated by a clock-enable-bar input and by reset.

Parameters:
- REFCLK_HROW_CK_SEL, 2'b00, ODIV2 mode: 00 = copy of O; 01 = O divided by 2; 10 = static 0; 11 = static 0 (reserved).
- NUM_LEDS, 4, number of LED output buffers (1..32).
- RST_SYNC_STAGES, 2, synchronizer depth for rst_n_sync (2..4).

Ports:
- sys_clk, in, 1, reference clock as seen after the differential receiver (I input).
- sys_rst, in, 1, asynchronous active-high reset.
- ceb, in, 1, clock-enable-bar; 1 gates off O and ODIV2.
- refclk_o, out, 1, gated reference clock (O).
- refclk_odiv2, out, 1, ODIV2 output per REFCLK_HROW_CK_SEL.
- rst_n_pad, in, 1, raw active-low board reset pad.
- rst_n_o, out, 1, buffered reset (IBUF O), combinational copy of rst_n_pad.
- rst_n_sync, out, 1, rst_n_pad synchronized to sys_clk; asserts asynchronously, deasserts synchronously.
- led_i, in, NUM_LEDS, LED drive from application.
- led_pad, out, NUM_LEDS, LED pads (OBUF O), combinational copy of led_i.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-high on sys_rst.
- Pass-throughs:
  - rst_n_o = rst_n_pad; led_pad = led_i.
  - Purely combinational, zero latency, unaffected by sys_rst and ceb.
- Enable term: en = ~sys_rst & ~ceb_eff.
  - ceb_eff = ceb (macro absent) or ceb_q (macro present).
- refclk_o = sys_clk & en. Reset value 0.
- Divider:
  - div_q toggles on each rising sys_clk edge while en = 1.
  - Cleared to 0 asynchronously by sys_rst; held at 0 while ceb_eff = 1.
  - First rising edge after enable takes div_q to 1.
- refclk_odiv2:
  - mode 00: equals refclk_o.
  - mode 01: equals div_q & en (period = 2 sys_clk periods, 50% duty, rising edges aligned to sys_clk rising edges).
  - mode 10/11: constant 0.
  - Reset value 0.
- rst_n_sync:
  - RST_SYNC_STAGES-flop chain on sys_clk rising edge, input rst_n_pad.
  - The chain is async-cleared to 0 when rst_n_pad = 0 OR sys_rst = 1.
  - Goes to 1 exactly RST_SYNC_STAGES rising edges after both are released.
  - Reset value 0.
- ceb toggling mid-divide (macro absent): div_q clears immediately; restarts from 0 when ceb falls.
- sys_rst asserted mid-operation: refclk_o, refclk_odiv2, div_q and rst_n_sync go to 0 immediately (same delta). Pass-throughs are unchanged.
- Simultaneous ceb fall and sys_rst release: enable follows the combinational expression; there is no priority beyond the AND.

Optional Feature:
- Macro REFCLK_CEB_SYNC_EN.
- When defined:
  - ceb is registered through two flops clocked on the falling edge of sys_clk; the second flop is ceb_q.
  - Both flops are async-set to 1 by sys_rst.
  - Gating changes only while sys_clk is low, so refclk_o has no runt pulses.
  - Enable/disable latency is 2 falling edges after a ceb change.
  - After sys_rst release, outputs stay 0 until 2 falling edges with ceb = 0.
- When undefined: ceb_eff = ceb, with combinational gating and zero latency.

Test Plan:
- Reset check: sys_rst = 1, ceb = 0, sys_clk running -> refclk_o = 0, refclk_odiv2 = 0, rst_n_sync = 0. Set led_i = 4'b1010 -> led_pad = 4'b1010. Toggle rst_n_pad -> rst_n_o follows immediately.
- Mode 00: release sys_rst, ceb = 0 -> refclk_o and refclk_odiv2 identical to sys_clk; 10 cycles give 10 rising edges each.
- Mode 01: 20 sys_clk cycles -> 10 refclk_odiv2 rising edges, each aligned to odd sys_clk rising edges starting with the first after release; duty 50%.
- ceb gating: drive ceb = 1 for 5 cycles mid-run -> refclk_o and refclk_odiv2 held 0. Return ceb = 0 -> div_q restarts at 0. With REFCLK_CEB_SYNC_EN, the change appears after 2 falling edges and no refclk_o pulse is shorter than half a period.
- Reset synchronizer: rst_n_pad 0 -> 1 with RST_SYNC_STAGES = 2 -> rst_n_sync rises on the 2nd sys_clk rising edge. rst_n_pad back to 0 -> rst_n_sync = 0 immediately without a clock.
- Mode 10: REFCLK_HROW_CK_SEL = 2'b10 -> refclk_odiv2 constant 0 over 50 cycles while refclk_o toggles normally.
